sram_ctrl: RTL
==============

# sram_ctrl

Memory-stage SRAM controller that turns single-cycle 32-bit data-memory requests from the MEM stage into two-halfword, wait-stated accesses on a 16-bit external SRAM. While an access is in progress it holds `ready` low. The top level drives `cache_freeze = ~ready` into every pipeline register, so it is the producer of the freeze that the stage registers consume. Results return on `readData` in the cycle `ready` rises.

## Interface
- `BASE_ADDR`, default 1024: byte address that maps to SRAM halfword 0.
- `WAIT_CYCLES`, default 5: SRAM cycles per halfword access; legal range 2..15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `wr_en` in 1: store request from MEM stage (MEM_W_EN).
- `rd_en` in 1: load request from MEM stage (MEM_R_EN).
- `address` in 32: byte address from ALU result; bits [1:0] are ignored.
- `writeData` in 32: store data (Val_Rm).
- `readData` out 32: load result.
- `ready` out 1: 1 means no access is pending or the access completes this cycle.
- `sram_addr` out 18: halfword address.
- `sram_dq_out` out 16: write data to pad.
- `sram_dq_oe` out 1: pad output enable.
- `sram_dq_in` in 16: read data from pad.
- `sram_we_n`, `sram_oe_n`, `sram_ce_n`, `sram_ub_n`, `sram_lb_n` out 1 each: active-low SRAM strobes.

## Operation
- Word index: `w = (address - BASE_ADDR) >> 2`, taken as 32-bit unsigned. Low halfword is at `sram_addr = {w[16:0],1'b0}`; high halfword is at `{w[16:0],1'b1}`.
- FSM states are IDLE, LO, HI, DONE; a wait counter `cnt` runs 0..WAIT_CYCLES-1.
- IDLE: if `wr_en|rd_en`, go to LO and clear `cnt`. Write wins if both are set; the operation type is latched on entry.
- LO: access the low halfword. When `cnt==WAIT_CYCLES-1`, go to HI and clear `cnt`. Otherwise increment `cnt`.
- HI: access the high halfword with the same counter rule, then go to DONE.
- DONE: go to IDLE unconditionally. This keeps a request from re-triggering while the pipeline advances.
- `ready = (IDLE & ~(rd_en|wr_en)) | DONE`. It is combinational and drops in the same cycle a request appears.
- During LO and HI:
  - `sram_ce_n=0` and `ub_n=lb_n=0`.
  - Read: `oe_n=0` and `dq_oe=0`.
  - Write: `dq_oe=1` and `sram_dq_out` is the selected half of `writeData`. `we_n=0` for `cnt<WAIT_CYCLES-1` and 1 on the last cycle, so the SRAM latches on the rising edge of `we_n`.
- Read capture: on the last cycle of LO, latch `sram_dq_in` into `rd_lo`; on the last cycle of HI, into `rd_hi`. `readData={rd_hi,rd_lo}` and holds until the next read overwrites it. Writes do not change it.
- In IDLE and DONE all strobes are 1, `dq_oe=0`, and `sram_addr` holds its last value.
- The pipeline holds `address`, `writeData`, `rd_en` and `wr_en` stable while `ready=0`, because the freeze guarantees this. The controller samples them combinationally and does not latch the address.

## Timing
- Reset values: state IDLE, `cnt=0`, `readData=0`, `sram_addr=0`, `sram_dq_out=0`, `dq_oe=0`, all `_n` strobes 1. `ready` is 1 unless a request is present.
- Request first seen in cycle T: LO runs T+1..T+W, HI runs T+W+1..T+2W, DONE is T+2W+1 (W = WAIT_CYCLES). `ready` is low for 2W+1 cycles (T..T+2W) and high in T+2W+1, when `readData` is valid.
- A back-to-back request from the next instruction is first seen in DONE+1 and restarts at IDLE with no gap cycle.
- Reset mid-access: state returns to IDLE immediately, strobes deassert and the pad is released. The partial write is lost; there is no retry.

## Configuration
- `SRAM_ADDR_CHECK_EN` defined: a request with `address < BASE_ADDR` or `w >= 2**17` skips LO and HI and goes IDLE→DONE. No strobe asserts and `ready` is low for exactly 1 cycle. A read returns `readData=32'h0`; a write is dropped.
- Not defined: no range check. `w` wraps modulo 2**17 and every request takes the full 2W+1 cycles.

## Structure
- Shared package `sram_pkg` holds:
  - state enum `sram_state_t` (IDLE, LO, HI, DONE);
  - `SRAM_AW=18` and `SRAM_DW=16`;
  - default `BASE_ADDR` and `WAIT_CYCLES` constants.
- One sub-module, `sram_wait_timer`: a clear/enable counter with a `last` output (`cnt==WAIT_CYCLES-1`), parameterised by `WAIT_CYCLES`.

## Test plan
- Reset then idle, no requests: `ready=1`, all strobes 1, `dq_oe=0`, `readData=0`.
- Write `address=1024`, `writeData=32'hDEADBEEF`, W=5:
  - `ready` low 11 cycles; `sram_addr` 0 with `dq_out=16'hBEEF`, then 1 with `16'hDEAD`.
  - `we_n` low 4 of 5 cycles in each half.
- Read back `address=1024` with the SRAM model: `readData=32'hDEADBEEF` in the cycle `ready` rises. Then read `address=1028`: `sram_addr` 2 then 3.
- Back-to-back load then store, both held by freeze: second access starts the cycle after DONE, the first `readData` is retained, and there are no duplicate accesses.
- Reset asserted on cycle 3 of the LO write: `we_n`, `ce_n` and `dq_oe` return to idle values asynchronously. After release, `ready=1`.
- With `SRAM_ADDR_CHECK_EN`, read `address=512`: `ready` low 1 cycle, `readData=0`, `ce_n` never low. Without the macro, the same request does a full access at wrapped `w`.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and constants for the 16-bit external SRAM controller.
// Optional build macro used by sram_ctrl: SRAM_ADDR_CHECK_EN.
package sram_pkg;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;

  localparam int DEF_BASE_ADDR   = 1024;
  localparam int DEF_WAIT_CYCLES = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } sram_state_t;

endpackage

// File: rtl/sram_wait_timer.sv
// Wait-state counter: clears on i_clr, counts 0..WAIT_CYCLES-1 while enabled,
// then wraps to 0 so the next halfword starts from a fresh count.
module sram_wait_timer
  import sram_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_last
);

  logic [3:0] r_cnt;
  logic       w_last;

  assign w_last = (r_cnt == 4'(WAIT_CYCLES - 1));
  assign o_last = w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// MEM-stage controller: splits a 32-bit request into two wait-stated 16-bit
// SRAM accesses, holding ready low meanwhile. Optional macro: SRAM_ADDR_CHECK_EN.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int BASE_ADDR   = DEF_BASE_ADDR,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        writeData,
  output logic [31:0]        readData,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic               sram_ce_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  sram_state_t r_state, w_state_next;
  logic              r_is_wr;
  logic [SRAM_DW-1:0] r_rd_lo, r_rd_hi;
  logic [SRAM_AW-1:0] r_sram_addr;
  logic [SRAM_DW-1:0] r_dq_out;

  logic [31:0]        w_diff;
  logic [16:0]        w_word;
  logic               w_in_range;
  logic               w_req;
  logic               w_last;
  logic               w_active;
  logic               w_drive;
  logic               w_tmr_clr;
  logic [SRAM_AW-1:0] w_addr_cur;
  logic [SRAM_DW-1:0] w_dq_cur;

  // Address is not latched: the pipeline freeze keeps it stable during the access.
  assign w_diff = address - 32'(BASE_ADDR);
  assign w_word = w_diff[18:2];

`ifdef SRAM_ADDR_CHECK_EN
  assign w_in_range = (address >= 32'(BASE_ADDR)) && (w_diff[31:19] == '0);
  logic w_unused;
  assign w_unused = ^w_diff[1:0];
`else
  assign w_in_range = 1'b1;
  logic w_unused;
  assign w_unused = ^{w_diff[31:19], w_diff[1:0]};
`endif

  assign w_req      = wr_en | rd_en;
  assign w_active   = (r_state == LO) || (r_state == HI);
  assign w_drive    = w_active & r_is_wr;
  assign w_tmr_clr  = (r_state == IDLE) || (r_state == DONE);
  assign w_addr_cur = {w_word, (r_state == HI)};
  assign w_dq_cur   = (r_state == HI) ? writeData[31:16] : writeData[15:0];

  sram_wait_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_tmr_clr),
    .i_en  (w_active),
    .o_last(w_last)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_req) w_state_next = w_in_range ? LO : DONE;
      LO:   if (w_last) w_state_next = HI;
      HI:   if (w_last) w_state_next = DONE;
      DONE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_is_wr     <= 1'b0;
      r_rd_lo     <= '0;
      r_rd_hi     <= '0;
      r_sram_addr <= '0;
      r_dq_out    <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && w_req) r_is_wr <= wr_en;
      if (w_active) r_sram_addr <= w_addr_cur;
      if (w_drive)  r_dq_out    <= w_dq_cur;
      // A rejected read returns zero rather than stale data.
      if (r_state == IDLE && w_req && !w_in_range && !wr_en) begin
        r_rd_lo <= '0;
        r_rd_hi <= '0;
      end
      if (r_state == LO && !r_is_wr && w_last) r_rd_lo <= sram_dq_in;
      if (r_state == HI && !r_is_wr && w_last) r_rd_hi <= sram_dq_in;
    end
  end

  assign ready       = ((r_state == IDLE) && !w_req) || (r_state == DONE);
  assign readData    = {r_rd_hi, r_rd_lo};
  assign sram_addr   = w_active ? w_addr_cur : r_sram_addr;
  assign sram_dq_out = w_drive ? w_dq_cur : r_dq_out;
  assign sram_dq_oe  = w_drive;
  assign sram_ce_n   = ~w_active;
  assign sram_ub_n   = ~w_active;
  assign sram_lb_n   = ~w_active;
  assign sram_oe_n   = ~(w_active & ~r_is_wr);
  // we_n rises on the last wait cycle so the SRAM latches on that edge.
  assign sram_we_n   = ~(w_drive & ~w_last);

endmodule
